ps2_keyboard_rx_fifo: RTL and testbench
=======================================

// Module: ps2_keyboard_rx_fifo
// PURPOSE
//  Parametrised PS/2 keyboard receiver: filters ps2clk, deserialises 11-bit frames and checks parity/stop.
//  Decodes E0 (extended) and F0 (break) prefixes into one key event per keystroke.
//  Buffers events in a show-ahead FIFO for the downstream consumer.
//  Sits between the PS/2 pins and the text/command logic; replaces the single-byte controller.
// PARAMETERS
//  FILTER_LEN     8        consecutive equal clk samples needed to accept a ps2clk level change
//  FIFO_DEPTH     8        event FIFO entries; power of two, >=2
//  TIMEOUT_CYCLES 200000   clk cycles without a ps2clk fall (mid-frame) before abort (2 ms @100 MHz)
// PORTS
//  clk         in   1   system clock, 100 MHz
//  reset       in   1   asynchronous, active-high; clears all state
//  ps2clk      in   1   raw PS/2 clock pin (asynchronous)
//  ps2data     in   1   raw PS/2 data pin (asynchronous)
//  rd_en       in   1   pop head event; ignored when key_valid=0
//  key_valid   out  1   FIFO not empty; head event presented on key_*
//  key_code    out  8   head event scan code (prefix bytes stripped)
//  key_break   out  1   head event is a release (F0 seen)
//  key_ext     out  1   head event is extended (E0 seen)
//  fifo_count  out  $clog2(FIFO_DEPTH)+1   occupancy, 0..FIFO_DEPTH
//  overflow    out  1   sticky; set when an event is dropped because the FIFO is full
//  frame_err   out  1   one-cycle pulse on parity error, bad stop bit or timeout
//  ascii_code  out  8   ASCII of head event (see CONFIGURATION)
// BEHAVIOUR
//  Reset values: all outputs 0, FSM=IDLE, FIFO empty, prefix flags clear, filtered clk=1.
//  Input path: 2-FF synchroniser on both pins. The filtered clk takes a new level only after FILTER_LEN
//   equal consecutive samples. A 1->0 transition of the filtered clk is a "fall" and samples ps2data.
//  FSM (advances on falls only, except timeout):
//   IDLE  : if data=0 (start bit) -> DATA, bit_cnt=0; else stay.
//   DATA  : shift LSB first; after bit 7 -> PARITY.
//   PARITY: store bit -> STOP.
//   STOP  : frame valid if stop=1 and the data byte plus parity bit have an odd number of ones; -> IDLE.
//   Any non-IDLE state with no fall for TIMEOUT_CYCLES -> IDLE, frame_err pulse, partial byte discarded.
//  Decoder (on a valid frame): E0 -> set ext flag; F0 -> set brk flag; any other byte -> push
//   {ext,brk,byte} and clear both flags. An invalid frame pulses frame_err and clears both flags.
//  Latency: push occurs 1 clk after the STOP fall; key_valid/fifo_count update on the following clk.
//  FIFO: show-ahead; key_* reflect the head combinationally from registered storage and hold while key_valid=0.
//   Pop on rd_en & key_valid. Push when full and no pop -> event dropped, overflow set (sticky until reset).
//   Push and pop in the same cycle when full -> both happen, no overflow. Pointers wrap modulo FIFO_DEPTH.
//  Asserting reset mid-frame aborts the frame immediately; no partial event is pushed.
// CONFIGURATION
//  PS2_ASCII_EN defined: ascii_code = set-2 map of the head key_code when key_valid & !key_ext, otherwise 0x00.
//   Map: letters -> uppercase 'A'..'Z' (1C->0x41), digits 0-9, 29->0x20, 5A->0x0D; unmapped codes -> 0x00.
//  PS2_ASCII_EN not defined: no lookup table is built; ascii_code is tied to 8'h00.
// TESTING
//  1) Frame 1C (parity 0, stop 1) -> 1 clk after STOP fall: key_valid=1, key_code=1C, brk=0, ext=0, ascii=0x41 (EN).
//  2) F0 (parity 1) then 1C -> exactly one event: key_code=1C, key_break=1, fifo_count=1.
//  3) E0,F0,75 -> one event: code 75, ext=1, brk=1, ascii_code=0x00; rd_en 1 clk -> key_valid=0, count=0.
//  4) 1C sent with parity 1 -> frame_err pulses once, nothing pushed; a following good 1C gives brk=0.
//  5) Stop ps2clk after 4 bits for >TIMEOUT_CYCLES -> frame_err, FSM IDLE; next full frame is received correctly.
//  6) FIFO_DEPTH+1 events, no reads -> count=FIFO_DEPTH, overflow=1, head is the first event; 1-clk glitch on ps2clk is ignored.

Source files
------------

// File: rtl/ps2_keyboard_rx_fifo.sv
// ps2_keyboard_rx_fifo: PS/2 keyboard receiver with prefix decoding and show-ahead event FIFO
// Ports: clk/reset (async, active-high); ps2clk/ps2data raw pins; rd_en pops head event;
//  key_valid/key_code/key_break/key_ext present head event; fifo_count occupancy;
//  overflow sticky drop flag; frame_err one-cycle error pulse; ascii_code head ASCII.
// Define PS2_ASCII_EN to build the set-2 to ASCII lookup; otherwise ascii_code is 8'h00.
module ps2_keyboard_rx_fifo #(
  parameter int FILTER_LEN = 8,
  parameter int FIFO_DEPTH = 8,
  parameter int TIMEOUT_CYCLES = 200000
) (
  input  logic clk,
  input  logic reset,
  input  logic ps2clk,
  input  logic ps2data,
  input  logic rd_en,
  output logic key_valid,
  output logic [7:0] key_code,
  output logic key_break,
  output logic key_ext,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic overflow,
  output logic frame_err,
  output logic [7:0] ascii_code
);
  localparam int CW = $clog2(FILTER_LEN) + 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int AW = $clog2(FIFO_DEPTH);
  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
  state_t state, state_n;
  logic [1:0] clk_s, data_s;
  logic flt, fall;
  logic [CW-1:0] flt_cnt;
  logic [TW-1:0] tmo;
  logic [2:0] bit_cnt, bit_cnt_n;
  logic [7:0] sh, sh_n;
  logic par, par_n, ok, ok_n, bad_n, ext, brk, push, pop, full, wr;
  logic [9:0] mem [FIFO_DEPTH];
  logic [9:0] hold, head;
  logic [AW-1:0] wp, rp;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      clk_s <= 2'b11;
      data_s <= 2'b11;
    end else begin
      clk_s <= {clk_s[0], ps2clk};
      data_s <= {data_s[0], ps2data};
    end
  // Filtered clock flips only after FILTER_LEN consecutive samples disagree with it.
  assign fall = flt & ~clk_s[1] & (flt_cnt == CW'(FILTER_LEN - 1));
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      flt <= 1'b1;
      flt_cnt <= '0;
    end else if (clk_s[1] == flt) flt_cnt <= '0;
    else if (flt_cnt == CW'(FILTER_LEN - 1)) begin
      flt <= clk_s[1];
      flt_cnt <= '0;
    end else flt_cnt <= flt_cnt + 1'b1;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      bit_cnt <= '0;
      sh <= '0;
      par <= 1'b0;
      tmo <= '0;
      ok <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state <= state_n;
      bit_cnt <= bit_cnt_n;
      sh <= sh_n;
      par <= par_n;
      tmo <= (fall || state == IDLE) ? '0 : tmo + 1'b1;
      ok <= ok_n;
      frame_err <= bad_n;
    end
  always_comb begin
    state_n = state;
    bit_cnt_n = bit_cnt;
    sh_n = sh;
    par_n = par;
    ok_n = 1'b0;
    bad_n = 1'b0;
    if (fall)
      case (state)
        IDLE: if (!data_s[1]) begin
          state_n = DATA;
          bit_cnt_n = '0;
        end
        DATA: begin
          sh_n = {data_s[1], sh[7:1]};
          bit_cnt_n = bit_cnt + 1'b1;
          state_n = (bit_cnt == 3'd7) ? PARITY : DATA;
        end
        PARITY: begin
          par_n = data_s[1];
          state_n = STOP;
        end
        default: begin
          state_n = IDLE;
          ok_n = data_s[1] & ^{sh, par};
          bad_n = ~(data_s[1] & ^{sh, par});
        end
      endcase
    else if (state != IDLE && tmo == TW'(TIMEOUT_CYCLES - 1)) begin
      state_n = IDLE;
      bad_n = 1'b1;
    end
  end
  // sh stays stable in IDLE, so the decoder can use it the cycle after STOP.
  assign push = ok & (sh != 8'hE0) & (sh != 8'hF0);
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      ext <= 1'b0;
      brk <= 1'b0;
    end else if (frame_err || push) begin
      ext <= 1'b0;
      brk <= 1'b0;
    end else if (ok) begin
      ext <= ext | (sh == 8'hE0);
      brk <= brk | (sh == 8'hF0);
    end
  assign key_valid = fifo_count != '0;
  assign full = fifo_count == (AW + 1)'(FIFO_DEPTH);
  assign pop = rd_en & key_valid;
  assign wr = push & (~full | pop);
  always_ff @(posedge clk)
    if (wr) mem[wp] <= {ext, brk, sh};
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      wp <= '0;
      rp <= '0;
      fifo_count <= '0;
      overflow <= 1'b0;
      hold <= '0;
    end else begin
      wp <= wr ? wp + 1'b1 : wp;
      rp <= pop ? rp + 1'b1 : rp;
      fifo_count <= fifo_count + {{AW{1'b0}}, wr} - {{AW{1'b0}}, pop};
      overflow <= overflow | (push & full & ~pop);
      hold <= pop ? mem[rp] : hold;
    end
  // Outputs keep the last popped event while the FIFO is empty.
  assign head = key_valid ? mem[rp] : hold;
  assign key_ext = head[9];
  assign key_break = head[8];
  assign key_code = head[7:0];
`ifdef PS2_ASCII_EN
  logic [7:0] map;
  always_comb begin
    map = 8'h00;
    case (key_code)
      8'h1C: map = 8'h41; 8'h32: map = 8'h42; 8'h21: map = 8'h43; 8'h23: map = 8'h44;
      8'h24: map = 8'h45; 8'h2B: map = 8'h46; 8'h34: map = 8'h47; 8'h33: map = 8'h48;
      8'h43: map = 8'h49; 8'h3B: map = 8'h4A; 8'h42: map = 8'h4B; 8'h4B: map = 8'h4C;
      8'h3A: map = 8'h4D; 8'h31: map = 8'h4E; 8'h44: map = 8'h4F; 8'h4D: map = 8'h50;
      8'h15: map = 8'h51; 8'h2D: map = 8'h52; 8'h1B: map = 8'h53; 8'h2C: map = 8'h54;
      8'h3C: map = 8'h55; 8'h2A: map = 8'h56; 8'h1D: map = 8'h57; 8'h22: map = 8'h58;
      8'h35: map = 8'h59; 8'h1A: map = 8'h5A;
      8'h45: map = 8'h30; 8'h16: map = 8'h31; 8'h1E: map = 8'h32; 8'h26: map = 8'h33;
      8'h25: map = 8'h34; 8'h2E: map = 8'h35; 8'h36: map = 8'h36; 8'h3D: map = 8'h37;
      8'h3E: map = 8'h38; 8'h46: map = 8'h39;
      8'h29: map = 8'h20; 8'h5A: map = 8'h0D;
      default: map = 8'h00;
    endcase
  end
  assign ascii_code = (key_valid & ~key_ext) ? map : 8'h00;
`else
  assign ascii_code = 8'h00;
`endif
endmodule

// File: tb/tb_ps2_keyboard_rx_fifo.sv
// tb_ps2_keyboard_rx_fifo: directed self-checking bench for ps2_keyboard_rx_fifo
module tb_ps2_keyboard_rx_fifo;
  localparam int FL = 4, DEPTH = 4, TMO = 300;
  logic clk = 1'b0, reset = 1'b1, ps2clk = 1'b1, ps2data = 1'b1, rd_en = 1'b0;
  logic key_valid, key_break, key_ext, overflow, frame_err;
  logic [7:0] key_code, ascii_code;
  logic [2:0] fifo_count;
  int errors = 0, checks = 0, fe_cnt = 0, fe_base;
  logic [7:0] asc_a;
  ps2_keyboard_rx_fifo #(.FILTER_LEN(FL), .FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset(reset), .ps2clk(ps2clk), .ps2data(ps2data), .rd_en(rd_en),
    .key_valid(key_valid), .key_code(key_code), .key_break(key_break), .key_ext(key_ext),
    .fifo_count(fifo_count), .overflow(overflow), .frame_err(frame_err), .ascii_code(ascii_code)
  );
  always #5 clk = ~clk;
  always @(negedge clk) if (frame_err) fe_cnt++;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic send(input logic [7:0] b, input logic flip, input int n);
    logic [10:0] f;
    f = {1'b1, ~^b ^ flip, b, 1'b0};
    for (int i = 0; i < n; i++) begin
      ps2data = f[i];
      repeat (10) @(negedge clk);
      ps2clk = 1'b0;
      repeat (20) @(negedge clk);
      ps2clk = 1'b1;
      repeat (10) @(negedge clk);
    end
    ps2data = 1'b1;
    repeat (10) @(negedge clk);
  endtask
  task automatic pop1();
    @(negedge clk) rd_en = 1'b1;
    @(negedge clk) rd_en = 1'b0;
  endtask
  initial begin
`ifdef PS2_ASCII_EN
    asc_a = 8'h41;
`else
    asc_a = 8'h00;
`endif
    repeat (3) @(negedge clk);
    chk("rst_valid", key_valid, 0);
    chk("rst_count", fifo_count, 0);
    chk("rst_code", key_code, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_ferr", frame_err, 0);
    chk("rst_ascii", ascii_code, 0);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    send(8'h1C, 1'b0, 11);
    chk("t1_valid", key_valid, 1);
    chk("t1_code", key_code, 8'h1C);
    chk("t1_brk", key_break, 0);
    chk("t1_ext", key_ext, 0);
    chk("t1_ascii", ascii_code, asc_a);
    pop1();
    chk("t1_pop_valid", key_valid, 0);
    chk("t1_pop_count", fifo_count, 0);
    send(8'hF0, 1'b0, 11);
    chk("t2_prefix_only", fifo_count, 0);
    send(8'h1C, 1'b0, 11);
    chk("t2_count", fifo_count, 1);
    chk("t2_code", key_code, 8'h1C);
    chk("t2_brk", key_break, 1);
    chk("t2_ext", key_ext, 0);
    pop1();
    send(8'hE0, 1'b0, 11);
    send(8'hF0, 1'b0, 11);
    send(8'h75, 1'b0, 11);
    chk("t3_count", fifo_count, 1);
    chk("t3_code", key_code, 8'h75);
    chk("t3_ext", key_ext, 1);
    chk("t3_brk", key_break, 1);
    chk("t3_ascii", ascii_code, 0);
    pop1();
    chk("t3_pop_valid", key_valid, 0);
    chk("t3_pop_count", fifo_count, 0);
    chk("t3_hold_code", key_code, 8'h75);
    fe_base = fe_cnt;
    send(8'hF0, 1'b0, 11);
    send(8'h1C, 1'b1, 11);
    chk("t4_ferr_pulses", fe_cnt - fe_base, 1);
    chk("t4_nopush", fifo_count, 0);
    send(8'h1C, 1'b0, 11);
    chk("t4_count", fifo_count, 1);
    chk("t4_brk_cleared", key_break, 0);
    pop1();
    fe_base = fe_cnt;
    send(8'h1C, 1'b0, 4);
    repeat (TMO + 50) @(negedge clk);
    chk("t5_ferr", fe_cnt - fe_base, 1);
    chk("t5_nopush", fifo_count, 0);
    send(8'h1C, 1'b0, 11);
    chk("t5_count", fifo_count, 1);
    chk("t5_code", key_code, 8'h1C);
    chk("t5_brk", key_break, 0);
    pop1();
    ps2data = 1'b0;
    repeat (5) @(negedge clk);
    ps2clk = 1'b0;
    @(negedge clk) ps2clk = 1'b1;
    repeat (5) @(negedge clk);
    ps2data = 1'b1;
    repeat (20) @(negedge clk);
    fe_base = fe_cnt;
    send(8'h16, 1'b0, 11);
    send(8'h1E, 1'b0, 11);
    send(8'h26, 1'b0, 11);
    send(8'h25, 1'b0, 11);
    send(8'h2E, 1'b0, 11);
    chk("t6_count", fifo_count, DEPTH);
    chk("t6_ovf", overflow, 1);
    chk("t6_head", key_code, 8'h16);
    chk("t6_noferr", fe_cnt - fe_base, 0);
    pop1();
    chk("t6_pop_count", fifo_count, DEPTH - 1);
    chk("t6_pop_head", key_code, 8'h1E);
    chk("t6_ovf_sticky", overflow, 1);
    send(8'h1C, 1'b0, 3);
    @(negedge clk) reset = 1'b1;
    @(negedge clk);
    chk("t7_rst_count", fifo_count, 0);
    chk("t7_rst_ovf", overflow, 0);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    send(8'h1C, 1'b0, 11);
    chk("t7_count", fifo_count, 1);
    chk("t7_code", key_code, 8'h1C);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
